snake_body_engine: RTL
======================

Name: snake_body_engine

Overview:
Parametrised successor of the fixed five-segment snake drawer. Holds head and body segment positions in a shift register of depth MAX_LEN. Grows on food events, rejects 180° reversals and detects wall and self collisions. Sits between the game FSM (game_state, direction, grow) and the VGA pixel mux (x_pos/y_pos in, active flags and rgb out).

Parameters:
SIZE, 5, segment edge length in pixels; also the step per move
BIT, 10, coordinate width
MAX_LEN, 32, maximum number of body segments (excluding head), >= INIT_LEN+1
INIT_LEN, 3, body segments after reset or re-init
X_START, 320, head start x (multiple of SIZE)
Y_START, 240, head start y (multiple of SIZE)
H_RES, 640, playfield width in pixels
V_RES, 480, playfield height in pixels
SNAKE_RGB, 3'b010, output colour

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
update  in  1  one-cycle move tick
direction  in  3  requested direction: IDLE=0, UP=1, DOWN=2, LEFT=3, RIGHT=4
game_state  in  2  PLAY=2'b01, GAME_OVER=2'b11; other codes mean hold
grow  in  1  one-cycle food-eaten pulse
x_pos  in  BIT  current pixel x
y_pos  in  BIT  current pixel y
head_active  out  1  pixel inside head box
body_active  out  1  pixel inside any active body box
wall_hit  out  1  sticky: move rejected at playfield edge
self_hit  out  1  sticky: move rejected into own body
length  out  $clog2(MAX_LEN+1)  active body segment count
rgb  out  3  SNAKE_RGB constant

Behaviour:
- Reset (reset=1), re-init (game_state==GAME_OVER on any edge), and INIT all take priority over everything else and produce the same state:
  - head=(X_START,Y_START); body[i]=(X_START-(i+1)*SIZE, Y_START) for i<INIT_LEN; other body entries don't-care.
  - length=INIT_LEN, cur_dir=IDLE, grow_pend=0, wall_hit=0, self_hit=0.
- Direction register cur_dir:
  - Sampled only on an update while in PLAY.
  - A requested direction that is the exact opposite of a non-IDLE cur_dir is ignored (cur_dir kept).
  - A request of IDLE while cur_dir is non-IDLE is also ignored.
  - From IDLE, any direction is accepted.
- grow pulse sets grow_pend (any cycle, any state except re-init). grow_pend is cleared on the next accepted move.
  - grow and an accepted move in the same cycle: the grow counts for that move.
- Move: on update && PLAY && !wall_hit && !self_hit && effective dir!=IDLE.
  - next_head = head ± SIZE on the axis of the effective direction.
- Wall check, done on the unwrapped value before any subtraction:
  - UP with head.y<SIZE; LEFT with head.x<SIZE; DOWN with head.y+SIZE > V_RES-SIZE; RIGHT with head.x+SIZE > H_RES-SIZE.
  - On a wall hit: wall_hit<=1 and no state moves.
- Self check: next_head equals body[i] for any i < (grow_pend ? length : length-1).
  - The tail cell vacates on a non-grow move and is excluded.
  - On a self hit: self_hit<=1 and no state moves. Wall check takes precedence if both apply.
- Accepted move, all in one clock:
  - body[0]<=head; body[i]<=body[i-1]; head<=next_head.
  - If grow_pend: length<=min(length+1, MAX_LEN). Saturation at MAX_LEN is silent; the snake keeps moving.
- Latency: positions, length and hit flags update on the clock edge that samples update; visible in the next cycle.
- Hit flags stay at 1 until reset or GAME_OVER. While a flag is set, further updates are ignored.
- Render (combinational from registers):
  - head_active = x∈[head.x, head.x+SIZE) && y∈[head.y, head.y+SIZE).
  - body_active = OR over i<length of the same box test on body[i]; entries with index ≥ length never light.
  - Compares are done at BIT+1 bits to avoid overflow on +SIZE.

Decomposition:
- Shared package snake_pkg: direction codes (IDLE/UP/DOWN/LEFT/RIGHT), game-state codes (PLAY/GAME_OVER), colour constants, and an opposite-direction function.
- Sub-module snake_seg_hit: BIT/SIZE-parametrised box test (px, py, sx, sy → hit). Generate-instantiated for the head, for each body entry in render, and reused as an equality test for the self check.

Test Plan:
- Reset, PLAY, direction=RIGHT, 3 updates → head=(335,240); body[0..2]=(330,240),(325,240),(320,240); length=3; flags 0.
- Moving RIGHT, request LEFT + update → head continues to x+5, cur_dir stays RIGHT; then request UP → head.y decreases by 5.
- grow pulse, then 2 updates → length 3→4 after the first update, stays 4 after the second; tail grows by one cell. Also check: with length=MAX_LEN, grow then update → length stays 32.
- Head at y=0, moving UP, update → wall_hit=1 and head unchanged; further updates ignored; GAME_OVER → head=(320,240), length=3, wall_hit=0.
- Grow to 5, then RIGHT, DOWN, LEFT, UP with updates → self_hit=1 on the UP move, head unchanged. Also check: length=3 square loop into the vacating tail → no self_hit.
- Scan x/y across the head and across body[length] (inactive) → head_active/body_active exact at box edges (x=head.x+4 hit, x=head.x+5 miss); inactive entry never lights.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared definitions for the snake body engine: direction and game-state
// codes, colour constants and the opposite-direction helper.
package snake_pkg;

    typedef enum logic [2:0] {
        DIR_IDLE  = 3'd0,
        DIR_UP    = 3'd1,
        DIR_DOWN  = 3'd2,
        DIR_LEFT  = 3'd3,
        DIR_RIGHT = 3'd4
    } dir_e;

    localparam logic [1:0] GS_PLAY      = 2'b01;
    localparam logic [1:0] GS_GAME_OVER = 2'b11;

    localparam logic [2:0] RGB_BLACK = 3'b000;
    localparam logic [2:0] RGB_GREEN = 3'b010;

    // Direction that would reverse the snake onto itself; IDLE has none.
    function automatic dir_e opposite_dir(input dir_e d);
        case (d)
            DIR_UP:    return DIR_DOWN;
            DIR_DOWN:  return DIR_UP;
            DIR_LEFT:  return DIR_RIGHT;
            DIR_RIGHT: return DIR_LEFT;
            default:   return DIR_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/snake_seg_hit.sv
// Box test: is point (px, py) inside the SIZE x SIZE square at (sx, sy)?
// Ports: px/py point, sx/sy square origin, hit combinational result.
// Sums are taken at BIT+1 bits so sx+SIZE cannot wrap.
module snake_seg_hit #(
    parameter int unsigned BIT  = 10,
    parameter int unsigned SIZE = 5
) (
    input  logic [BIT-1:0] px,
    input  logic [BIT-1:0] py,
    input  logic [BIT-1:0] sx,
    input  logic [BIT-1:0] sy,
    output logic           hit
);

    localparam int unsigned W = BIT + 1;

    assign hit = (W'(px) >= W'(sx)) && (W'(px) < W'(sx) + W'(SIZE)) &&
                 (W'(py) >= W'(sy)) && (W'(py) < W'(sy) + W'(SIZE));

endmodule

// File: rtl/snake_body_engine.sv
// Snake head/body position engine: shift-register body of depth MAX_LEN,
// growth on food, reversal rejection, wall and self collision, pixel render.
// Ports: clk/reset (sync, active-high); update move tick; direction request;
// game_state PLAY/GAME_OVER; grow food pulse; x_pos/y_pos pixel under scan;
// head_active/body_active render flags; wall_hit/self_hit sticky collision
// flags; length active body count; rgb constant colour.
module snake_body_engine
    import snake_pkg::*;
#(
    parameter int unsigned BIT       = 10,
    parameter int unsigned SIZE      = 5,
    parameter int unsigned MAX_LEN   = 32,
    parameter int unsigned INIT_LEN  = 3,
    parameter int unsigned X_START   = 320,
    parameter int unsigned Y_START   = 240,
    parameter int unsigned H_RES     = 640,
    parameter int unsigned V_RES     = 480,
    parameter logic [2:0]  SNAKE_RGB = RGB_GREEN
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           update,
    input  logic [2:0]                     direction,
    input  logic [1:0]                     game_state,
    input  logic                           grow,
    input  logic [BIT-1:0]                 x_pos,
    input  logic [BIT-1:0]                 y_pos,
    output logic                           head_active,
    output logic                           body_active,
    output logic                           wall_hit,
    output logic                           self_hit,
    output logic [$clog2(MAX_LEN+1)-1:0]   length,
    output logic [2:0]                     rgb
);

    localparam int unsigned LW = $clog2(MAX_LEN + 1);
    localparam int unsigned W  = BIT + 1;

    logic [BIT-1:0]     head_x, head_y;
    logic [BIT-1:0]     body_x [MAX_LEN];
    logic [BIT-1:0]     body_y [MAX_LEN];
    dir_e               cur_dir, req_dir, eff_dir;
    logic               grow_pend, grow_eff, reinit, step_req;
    logic               wall_c, self_c, move_c;
    logic [BIT-1:0]     next_x, next_y;
    logic [LW-1:0]      self_lim;
    logic [MAX_LEN-1:0] body_box, self_box, body_mask, self_mask;

    assign reinit   = reset || (game_state == GS_GAME_OVER);
    assign step_req = update && (game_state == GS_PLAY) && !wall_hit && !self_hit;
    assign grow_eff = grow_pend || grow;
    // On a non-grow move the tail cell vacates, so it is not an obstacle.
    assign self_lim = grow_eff ? length : length - LW'(1);
    assign rgb      = SNAKE_RGB;

    // Effective direction: undefined codes act as IDLE; reversals and IDLE
    // requests are ignored once moving.
    always_comb begin
        req_dir = (direction <= 3'd4) ? dir_e'(direction) : DIR_IDLE;
        eff_dir = req_dir;
        if (cur_dir != DIR_IDLE &&
            (req_dir == DIR_IDLE || req_dir == opposite_dir(cur_dir)))
            eff_dir = cur_dir;
    end

    // Candidate head and wall test on the unwrapped coordinate.
    always_comb begin
        next_x = head_x;
        next_y = head_y;
        wall_c = 1'b0;
        case (eff_dir)
            DIR_UP: begin
                wall_c = head_y < BIT'(SIZE);
                next_y = head_y - BIT'(SIZE);
            end
            DIR_DOWN: begin
                wall_c = (W'(head_y) + W'(SIZE)) > W'(V_RES - SIZE);
                next_y = head_y + BIT'(SIZE);
            end
            DIR_LEFT: begin
                wall_c = head_x < BIT'(SIZE);
                next_x = head_x - BIT'(SIZE);
            end
            DIR_RIGHT: begin
                wall_c = (W'(head_x) + W'(SIZE)) > W'(H_RES - SIZE);
                next_x = head_x + BIT'(SIZE);
            end
            default: ;
        endcase
    end

    // Per-entry enables for render and for the self-collision window.
    always_comb begin
        body_mask = '0;
        self_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            body_mask[i] = LW'(i) < length;
            self_mask[i] = LW'(i) < self_lim;
        end
    end

    assign self_c      = |(self_box & self_mask);
    assign body_active = |(body_box & body_mask);
    assign move_c      = step_req && (eff_dir != DIR_IDLE) && !wall_c && !self_c;

    snake_seg_hit #(.BIT(BIT), .SIZE(SIZE)) u_head_hit (
        .px(x_pos), .py(y_pos), .sx(head_x), .sy(head_y), .hit(head_active)
    );

    // Grid-aligned positions make the box test an equality test for self_box.
    for (genvar g = 0; g < MAX_LEN; g++) begin : g_seg
        snake_seg_hit #(.BIT(BIT), .SIZE(SIZE)) u_render (
            .px(x_pos), .py(y_pos), .sx(body_x[g]), .sy(body_y[g]), .hit(body_box[g])
        );
        snake_seg_hit #(.BIT(BIT), .SIZE(SIZE)) u_self (
            .px(next_x), .py(next_y), .sx(body_x[g]), .sy(body_y[g]), .hit(self_box[g])
        );
    end

    // Position, length, direction and flag registers.
    always_ff @(posedge clk) begin
        if (reinit) begin
            head_x <= BIT'(X_START);
            head_y <= BIT'(Y_START);
            for (int i = 0; i < INIT_LEN; i++) begin
                body_x[i] <= BIT'(X_START - (i + 1) * SIZE);
                body_y[i] <= BIT'(Y_START);
            end
            length    <= LW'(INIT_LEN);
            cur_dir   <= DIR_IDLE;
            grow_pend <= 1'b0;
            wall_hit  <= 1'b0;
            self_hit  <= 1'b0;
        end else begin
            if (step_req)
                cur_dir <= eff_dir;
            if (step_req && eff_dir != DIR_IDLE) begin
                if (wall_c)
                    wall_hit <= 1'b1;
                else if (self_c)
                    self_hit <= 1'b1;
            end
            if (move_c) begin
                head_x    <= next_x;
                head_y    <= next_y;
                body_x[0] <= head_x;
                body_y[0] <= head_y;
                for (int i = 1; i < MAX_LEN; i++) begin
                    body_x[i] <= body_x[i-1];
                    body_y[i] <= body_y[i-1];
                end
                if (grow_eff && length < LW'(MAX_LEN))
                    length <= length + LW'(1);
                grow_pend <= 1'b0;
            end else if (grow) begin
                grow_pend <= 1'b1;
            end
        end
    end

endmodule
